vga_bus_responder: RTL and testbench
====================================

Name: vga_bus_responder

Overview:
- Target (responder) end of the VGA-side ISA-style bus that the Zorro II bridge CPLD drives: BALE, SA0/SA12, IOR/IOW/MEMR/MEMW, DG[15:0] and WAIT.
- Implements a small indexed word buffer with an IO-mapped index/control port and a memory-mapped data port with auto-increment.
- Inserts programmable memory wait states on WAIT.
- Serves as the on-board scratch/loopback target for bridge bring-up and as the verification counterpart of the bridge.

Parameters:
- DEPTH_BITS, 8: buffer address width (buffer holds 2^DEPTH_BITS words).
- WAIT_DEFAULT, 2: reset value of the memory wait-state count (0..15).

Ports:
- mclk  in  1  VGA clock, ~28 MHz; the same clock the bridge uses; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- BALE  in  1  address latch enable, active low during a cycle.
- SA0  in  1  address bit 0.
- SA12  in  1  address bit 12.
- IOR  in  1  IO read strobe, active low.
- IOW  in  1  IO write strobe, active low.
- MEMR  in  1  memory read strobe, active low.
- MEMW  in  1  memory write strobe, active low.
- DG  inout  16  VGA data bus; driven only during reads.
- WAIT  out  1  1 = ready, 0 = hold off; open-collector semantics not required.

Behaviour:
- Reset values:
  - WAIT=1; DG released (Z).
  - index=0; wait_cnt_cfg=WAIT_DEFAULT; err=0; state=IDLE.
  - Buffer contents undefined.
  - Reset asserted mid-cycle aborts it: no commit, no index increment, DG released and WAIT=1 in the same cycle.
- Inputs are synchronous to mclk; no synchronizers. Each input is registered once (s_*), and all decisions use the registered copies.
- Address latch: on the first cycle s_BALE==0 after s_BALE==1, capture a0<=SA0 and a12<=SA12. These are held until the cycle ends.
- State machine:
  - IDLE: wait for exactly one s_strobe low.
    - Exactly one low: go to ACCESS and load wcnt <= (memory cycle ? wait_cnt_cfg : 0).
    - More than one low: set err=1, go to ABORT.
  - ACCESS:
    - If wcnt != 0: WAIT=0 and wcnt-- each cycle.
    - If wcnt == 0: WAIT=1 and go to HOLD.
    - WAIT goes low one cycle after the strobe edge is sampled, which is before the bridge's WAIT sample (4 cycles after the strobe assert).
  - HOLD: wait for the strobe to rise (s_strobe==1). On the rise, commit the write (data is still valid, because the bridge holds DG for 3 more cycles), update index, and go to IDLE.
  - ABORT: WAIT=1, DG released, no commit. Return to IDLE when all strobes are high.
- Read data: DG is driven from a register loaded in the cycle entering ACCESS. The output enable asserts from the cycle after strobe sample until the cycle after strobe rise.
- IO map (SA12 ignored; a0 selects the register):
  - a0=0 write: index <= DG[DEPTH_BITS-1:0].
  - a0=0 read: returns {zero-pad, index}.
  - a0=1 write: wait_cnt_cfg <= DG[3:0]; writing DG[15]=1 clears err.
  - a0=1 read: returns {err, 11'b0, wait_cnt_cfg}.
- Memory map (a0 is the byte-lane flag and is ignored; word access only):
  - a12=0: data port. Read returns buf[index]; write sets buf[index] <= DG. Index increments by 1 at the end of the cycle and wraps from 2^DEPTH_BITS-1 to 0.
  - a12=1: peek port. Same access, but index does not change.
- Index width arithmetic is modulo 2^DEPTH_BITS. Upper DG bits on an index write are ignored.
- IO cycles never pull WAIT low, because the bridge ignores WAIT on IO cycles.
- A strobe that asserts without a preceding BALE uses the last latched address.

Decomposition:
- Package vga_resp_pkg holds:
  - state enum {IDLE, ACCESS, HOLD, ABORT};
  - IO offsets IO_INDEX=0, IO_CTRL=1;
  - memory port selects PORT_DATA=0, PORT_PEEK=1;
  - the ERR_CLR bit position, 15.
- One sub-module, vga_resp_ram: single-port synchronous 2^DEPTH_BITS x 16 RAM with write enable and registered read.

Test Plan:
- Reset: assert reset while WAIT is low mid-ACCESS → WAIT=1 and DG=Z in the same cycle; index reads 0 after release; ctrl reads 0x0002.
- IO index: IOW a0=0 with DG=0x01FE → IOR a0=0 returns 0x00FE.
- Burst with wrap: with index=0xFE, write 0x1111, 0x2222, 0x3333 via MEMW a12=0 → index=0x01. Set index=0xFE and read back → data is 0x1111, 0x2222, 0x3333.
- Peek: index=5, buf[5]=0xBEEF; MEMR a12=1 twice → 0xBEEF both times, index still 5.
- Wait states: ctrl write 0x0004, then MEMR → WAIT low exactly 4 cycles starting 2 cycles after the MEMR fall; an IOR cycle gives WAIT constantly 1. With ctrl=0, WAIT never goes low.
- Illegal cycle: IOW and MEMW low together → no buffer/index change and ctrl reads 0x8002. Write ctrl with DG=0x8002 → reads 0x0002.

Source files
------------

// File: rtl/vga_resp_pkg.sv
// Shared definitions for the VGA-side bus responder: FSM states, register
// offsets, port selects and a small strobe-counting helper.
package vga_resp_pkg;

    // Bus cycle tracking states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2,
        ABORT  = 2'd3
    } state_t;

    // IO register offsets selected by the latched SA0
    localparam logic IO_INDEX = 1'b0;
    localparam logic IO_CTRL  = 1'b1;

    // Memory port selects chosen by the latched SA12
    localparam logic PORT_DATA = 1'b0;
    localparam logic PORT_PEEK = 1'b1;

    // Writing a one to this control bit clears the sticky error flag
    localparam int ERR_CLR = 15;

    // Number of active-low strobes currently asserted
    function automatic logic [2:0] count_low(input logic [3:0] strobes);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (!strobes[i]) begin
                n = n + 3'd1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/vga_resp_ram.sv
// Single-port synchronous word buffer behind the responder's data port.
// Reads are registered and return the old contents on a same-cycle write.
module vga_resp_ram #(
    parameter int DEPTH_BITS = 8
) (
    input  logic                  mclk,
    input  logic                  we,
    input  logic [DEPTH_BITS-1:0] addr,
    input  logic [15:0]           wdata,
    output logic [15:0]           rdata
);

    logic [15:0] mem [0:(1<<DEPTH_BITS)-1];

    // Write on enable, and always register the word at the current address
    always_ff @(posedge mclk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/vga_bus_responder.sv
// Target end of the VGA-side ISA-style bus driven by the bridge CPLD.
// Provides an index/control register pair on IO and an auto-incrementing
// data port plus a non-incrementing peek port on memory, with programmable
// memory wait states signalled on WAIT.
module vga_bus_responder
    import vga_resp_pkg::*;
#(
    parameter int DEPTH_BITS   = 8,
    parameter int WAIT_DEFAULT = 2
) (
    input  logic        mclk,
    input  logic        reset,
    input  logic        BALE,
    input  logic        SA0,
    input  logic        SA12,
    input  logic        IOR,
    input  logic        IOW,
    input  logic        MEMR,
    input  logic        MEMW,
    inout  wire  [15:0] DG,
    output logic        WAIT
);

    // Registered copies of the bus pins; every decision uses these
    logic        s_bale;
    logic        s_bale_d;
    logic        s_sa0;
    logic        s_sa12;
    logic        s_ior;
    logic        s_iow;
    logic        s_memr;
    logic        s_memw;
    logic [15:0] s_dg;

    // Address latched at the start of a cycle
    logic a0;
    logic a12;

    // Cycle tracking
    state_t     state;
    logic [3:0] wcnt;
    logic       cyc_io;
    logic       cyc_wr;

    // Programmer-visible registers
    logic [DEPTH_BITS-1:0] index;
    logic [3:0]            wait_cfg;
    logic                  err;

    // Read data path
    logic        dg_oe;
    logic [15:0] dg_q;
    logic [15:0] ram_q;

    // Decode helpers
    logic [3:0]  strobes;
    logic [2:0]  low_cnt;
    logic        new_io;
    logic        new_wr;
    logic        cur_strobe;
    logic        commit;
    logic        ram_we;
    logic        index_inc;
    logic        io_index_wr;
    logic        io_ctrl_wr;
    logic [15:0] idx_word;
    logic [15:0] ctrl_word;
    logic [15:0] rd_mux;

    // Register every bus input once; strobes and BALE idle high
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            s_bale   <= 1'b1;
            s_bale_d <= 1'b1;
            s_sa0    <= 1'b0;
            s_sa12   <= 1'b0;
            s_ior    <= 1'b1;
            s_iow    <= 1'b1;
            s_memr   <= 1'b1;
            s_memw   <= 1'b1;
            s_dg     <= 16'h0000;
        end else begin
            s_bale   <= BALE;
            s_bale_d <= s_bale;
            s_sa0    <= SA0;
            s_sa12   <= SA12;
            s_ior    <= IOR;
            s_iow    <= IOW;
            s_memr   <= MEMR;
            s_memw   <= MEMW;
            s_dg     <= DG;
        end
    end

    // Capture the address on the falling edge of BALE; a strobe with no
    // fresh BALE simply reuses whatever was latched last
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            a0  <= 1'b0;
            a12 <= 1'b0;
        end else if (!s_bale && s_bale_d) begin
            a0  <= s_sa0;
            a12 <= s_sa12;
        end
    end

    // Strobe decode, read-data selection and commit qualification
    always_comb begin
        strobes  = {s_ior, s_iow, s_memr, s_memw};
        low_cnt  = count_low(strobes);
        new_io   = !s_ior || !s_iow;
        new_wr   = !s_iow || !s_memw;

        idx_word = 16'h0000;
        idx_word[DEPTH_BITS-1:0] = index;
        ctrl_word = {err, 11'b0, wait_cfg};

        rd_mux = ram_q;
        if (new_io) begin
            unique case (a0)
                IO_INDEX: rd_mux = idx_word;
                IO_CTRL:  rd_mux = ctrl_word;
            endcase
        end

        unique case ({cyc_io, cyc_wr})
            2'b00:   cur_strobe = s_memr;
            2'b01:   cur_strobe = s_memw;
            2'b10:   cur_strobe = s_ior;
            default: cur_strobe = s_iow;
        endcase

        commit = (state == HOLD) && cur_strobe;
        ram_we = commit && !cyc_io && cyc_wr;

        index_inc = 1'b0;
        unique case (a12)
            PORT_DATA: index_inc = commit && !cyc_io;
            PORT_PEEK: index_inc = 1'b0;
        endcase

        io_index_wr = 1'b0;
        io_ctrl_wr  = 1'b0;
        unique case (a0)
            IO_INDEX: io_index_wr = commit && cyc_io && cyc_wr;
            IO_CTRL:  io_ctrl_wr  = commit && cyc_io && cyc_wr;
        endcase
    end

    // Cycle state machine: qualify the strobe, count wait states, wait for
    // the strobe to rise, and own the read-data output enable
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            wcnt   <= 4'd0;
            cyc_io <= 1'b0;
            cyc_wr <= 1'b0;
            dg_oe  <= 1'b0;
            dg_q   <= 16'h0000;
        end else begin
            unique case (state)
                IDLE: begin
                    if (low_cnt == 3'd1) begin
                        state  <= ACCESS;
                        cyc_io <= new_io;
                        cyc_wr <= new_wr;
                        wcnt   <= new_io ? 4'd0 : wait_cfg;
                        dg_oe  <= !new_wr;
                        dg_q   <= rd_mux;
                    end else if (low_cnt > 3'd1) begin
                        state <= ABORT;
                    end
                end
                ACCESS: begin
                    if (wcnt != 4'd0) begin
                        wcnt <= wcnt - 4'd1;
                    end else begin
                        state <= HOLD;
                    end
                    // Keep memory read data tracking the buffer so that a
                    // cycle started right after a commit still returns the
                    // word at the updated index
                    if (!cyc_io && !cyc_wr) begin
                        dg_q <= ram_q;
                    end
                end
                HOLD: begin
                    if (cur_strobe) begin
                        state <= IDLE;
                        dg_oe <= 1'b0;
                    end
                end
                ABORT: begin
                    dg_oe <= 1'b0;
                    if (&strobes) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    dg_oe <= 1'b0;
                end
            endcase
        end
    end

    // Index pointer, wait-state configuration and sticky error flag
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            index    <= '0;
            wait_cfg <= 4'(WAIT_DEFAULT);
            err      <= 1'b0;
        end else begin
            if (state == IDLE && low_cnt > 3'd1) begin
                err <= 1'b1;
            end else if (io_ctrl_wr) begin
                wait_cfg <= s_dg[3:0];
                if (s_dg[ERR_CLR]) begin
                    err <= 1'b0;
                end
            end

            if (io_index_wr) begin
                index <= s_dg[DEPTH_BITS-1:0];
            end else if (index_inc) begin
                index <= index + DEPTH_BITS'(1);
            end
        end
    end

    // Hold the bridge off only while memory wait states remain
    assign WAIT = !((state == ACCESS) && (wcnt != 4'd0));

    // Drive the data bus only during reads
    assign DG = dg_oe ? dg_q : 16'hzzzz;

    vga_resp_ram #(
        .DEPTH_BITS (DEPTH_BITS)
    ) u_ram (
        .mclk  (mclk),
        .we    (ram_we),
        .addr  (index),
        .wdata (s_dg),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_vga_bus_responder.sv
// Directed bench for the VGA bus responder, acting as the bridge side of the
// bus and comparing readback against hand-computed values.
module tb_vga_bus_responder;

    localparam int K_IOR     = 0;
    localparam int K_IOW     = 1;
    localparam int K_MEMR    = 2;
    localparam int K_MEMW    = 3;
    localparam int K_ILLEGAL = 4;

    logic        mclk;
    logic        reset;
    logic        BALE;
    logic        SA0;
    logic        SA12;
    logic        IOR;
    logic        IOW;
    logic        MEMR;
    logic        MEMW;
    wire  [15:0] DG;
    logic        WAIT;

    logic [15:0] dg_drv;
    logic        dg_en;
    logic [15:0] rd;

    int check_count;
    int fail_count;
    int wait_low_cnt;
    int wait_first_low;

    assign DG = dg_en ? dg_drv : 16'hzzzz;

    vga_bus_responder #(
        .DEPTH_BITS   (8),
        .WAIT_DEFAULT (2)
    ) dut (
        .mclk  (mclk),
        .reset (reset),
        .BALE  (BALE),
        .SA0   (SA0),
        .SA12  (SA12),
        .IOR   (IOR),
        .IOW   (IOW),
        .MEMR  (MEMR),
        .MEMW  (MEMW),
        .DG    (DG),
        .WAIT  (WAIT)
    );

    // Free-running bus clock
    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    // Guard against a hung run
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", check_count, fail_count);
        $fatal(1, "[TB] watchdog");
    end

    // Count one comparison and report it if the values differ
    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Run one complete bridge-style bus cycle and record WAIT behaviour
    task automatic applyStimulus(input int kind, input logic addr_bit, input logic [15:0] wdata, output logic [15:0] rdata);
        int  n;
        bit  done;
        bit  is_write;
        is_write = (kind == K_IOW) || (kind == K_MEMW) || (kind == K_ILLEGAL);

        @(posedge mclk);
        #1;
        BALE = 1'b0;
        if (kind == K_IOR || kind == K_IOW) begin
            SA0  = addr_bit;
            SA12 = 1'b0;
        end else begin
            SA0  = 1'b0;
            SA12 = addr_bit;
        end
        repeat (2) @(posedge mclk);
        #1;
        if (is_write) begin
            dg_drv = wdata;
            dg_en  = 1'b1;
        end
        case (kind)
            K_IOR:   IOR  = 1'b0;
            K_IOW:   IOW  = 1'b0;
            K_MEMR:  MEMR = 1'b0;
            K_MEMW:  MEMW = 1'b0;
            default: begin
                IOW  = 1'b0;
                MEMW = 1'b0;
            end
        endcase

        n = 0;
        done = 1'b0;
        wait_low_cnt = 0;
        wait_first_low = 0;
        while (!done) begin
            @(posedge mclk);
            n++;
            @(negedge mclk);
            if (WAIT == 1'b0) begin
                wait_low_cnt++;
                if (wait_first_low == 0) begin
                    wait_first_low = n;
                end
            end
            if (n >= 5 && WAIT == 1'b1) begin
                done = 1'b1;
            end else if (n >= 60) begin
                checkOutput("wait_bound", {15'b0, WAIT}, 16'h0001);
                done = 1'b1;
            end
        end
        rdata = DG;

        @(posedge mclk);
        #1;
        IOR  = 1'b1;
        IOW  = 1'b1;
        MEMR = 1'b1;
        MEMW = 1'b1;
        if (is_write) begin
            repeat (3) @(posedge mclk);
            #1;
            dg_en = 1'b0;
        end
        BALE = 1'b1;
        repeat (3) @(posedge mclk);
    endtask

    initial begin
        check_count = 0;
        fail_count  = 0;
        reset  = 1'b1;
        BALE   = 1'b1;
        SA0    = 1'b0;
        SA12   = 1'b0;
        IOR    = 1'b1;
        IOW    = 1'b1;
        MEMR   = 1'b1;
        MEMW   = 1'b1;
        dg_en  = 1'b0;
        dg_drv = 16'h0000;

        $display("[TB] reset checks");
        repeat (3) @(posedge mclk);
        @(negedge mclk);
        checkOutput("rst_wait", {15'b0, WAIT}, 16'h0001);
        checkOutput("rst_dg_oe", {15'b0, dut.dg_oe}, 16'h0000);
        @(posedge mclk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge mclk);

        // Start a memory read and reset in the middle of its wait states
        #1;
        BALE = 1'b0;
        SA12 = 1'b0;
        repeat (2) @(posedge mclk);
        #1;
        MEMR = 1'b0;
        repeat (2) @(posedge mclk);
        @(negedge mclk);
        checkOutput("mid_wait_low", {15'b0, WAIT}, 16'h0000);
        checkOutput("mid_dg_oe", {15'b0, dut.dg_oe}, 16'h0001);
        reset = 1'b1;
        #1;
        checkOutput("abort_wait", {15'b0, WAIT}, 16'h0001);
        checkOutput("abort_dg_oe", {15'b0, dut.dg_oe}, 16'h0000);
        #1;
        MEMR = 1'b1;
        BALE = 1'b1;
        repeat (2) @(posedge mclk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge mclk);

        applyStimulus(K_IOR, 1'b0, 16'h0000, rd);
        checkOutput("post_rst_index", rd, 16'h0000);
        applyStimulus(K_IOR, 1'b1, 16'h0000, rd);
        checkOutput("post_rst_ctrl", rd, 16'h0002);

        $display("[TB] index register");
        applyStimulus(K_IOW, 1'b0, 16'h01FE, rd);
        applyStimulus(K_IOR, 1'b0, 16'h0000, rd);
        checkOutput("index_trunc", rd, 16'h00FE);

        $display("[TB] burst with wrap");
        applyStimulus(K_MEMW, 1'b0, 16'h1111, rd);
        applyStimulus(K_MEMW, 1'b0, 16'h2222, rd);
        applyStimulus(K_MEMW, 1'b0, 16'h3333, rd);
        applyStimulus(K_IOR, 1'b0, 16'h0000, rd);
        checkOutput("burst_wr_index", rd, 16'h0001);
        applyStimulus(K_IOW, 1'b0, 16'h00FE, rd);
        applyStimulus(K_MEMR, 1'b0, 16'h0000, rd);
        checkOutput("burst_rd0", rd, 16'h1111);
        applyStimulus(K_MEMR, 1'b0, 16'h0000, rd);
        checkOutput("burst_rd1", rd, 16'h2222);
        applyStimulus(K_MEMR, 1'b0, 16'h0000, rd);
        checkOutput("burst_rd2", rd, 16'h3333);
        applyStimulus(K_IOR, 1'b0, 16'h0000, rd);
        checkOutput("burst_rd_index", rd, 16'h0001);

        $display("[TB] peek port");
        applyStimulus(K_IOW, 1'b0, 16'h0005, rd);
        applyStimulus(K_MEMW, 1'b1, 16'hBEEF, rd);
        applyStimulus(K_IOR, 1'b0, 16'h0000, rd);
        checkOutput("peek_wr_index", rd, 16'h0005);
        applyStimulus(K_MEMR, 1'b1, 16'h0000, rd);
        checkOutput("peek_rd0", rd, 16'hBEEF);
        applyStimulus(K_MEMR, 1'b1, 16'h0000, rd);
        checkOutput("peek_rd1", rd, 16'hBEEF);
        applyStimulus(K_IOR, 1'b0, 16'h0000, rd);
        checkOutput("peek_rd_index", rd, 16'h0005);

        $display("[TB] wait states");
        applyStimulus(K_IOW, 1'b1, 16'h0004, rd);
        applyStimulus(K_IOR, 1'b1, 16'h0000, rd);
        checkOutput("ctrl_wait4", rd, 16'h0004);
        checkOutput("io_wait_low_cnt", 16'(wait_low_cnt), 16'd0);
        applyStimulus(K_MEMR, 1'b1, 16'h0000, rd);
        checkOutput("mem_wait_first", 16'(wait_first_low), 16'd2);
        checkOutput("mem_wait_cnt", 16'(wait_low_cnt), 16'd4);
        applyStimulus(K_IOW, 1'b1, 16'h0000, rd);
        applyStimulus(K_MEMR, 1'b1, 16'h0000, rd);
        checkOutput("mem_wait0_cnt", 16'(wait_low_cnt), 16'd0);

        $display("[TB] illegal cycle");
        applyStimulus(K_IOW, 1'b1, 16'h0002, rd);
        applyStimulus(K_IOW, 1'b0, 16'h0010, rd);
        applyStimulus(K_MEMW, 1'b1, 16'hAAAA, rd);
        applyStimulus(K_ILLEGAL, 1'b0, 16'h5555, rd);
        applyStimulus(K_IOR, 1'b0, 16'h0000, rd);
        checkOutput("illegal_index", rd, 16'h0010);
        applyStimulus(K_MEMR, 1'b1, 16'h0000, rd);
        checkOutput("illegal_buf", rd, 16'hAAAA);
        applyStimulus(K_IOR, 1'b1, 16'h0000, rd);
        checkOutput("illegal_err", rd, 16'h8002);
        applyStimulus(K_IOW, 1'b1, 16'h8002, rd);
        applyStimulus(K_IOR, 1'b1, 16'h0000, rd);
        checkOutput("err_cleared", rd, 16'h0002);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
